// File: rtl/lim_scheduler_if.sv
// lim_scheduler_if: start/result handshake between lim_scheduler (master) and the
// shared top/bottom limit detector (slave).
interface lim_scheduler_if #(
    parameter int DATA_W = 8
);
    logic              det_start;
    logic [DATA_W-1:0] det_level;
    logic [DATA_W-1:0] det_top_th;
    logic [DATA_W-1:0] det_bott_th;
    logic              det_done;
    logic              det_top_lim;
    logic              det_bott_lim;

    modport master (
        output det_start, det_level, det_top_th, det_bott_th,
        input  det_done, det_top_lim, det_bott_lim
    );

    modport slave (
        input  det_start, det_level, det_top_th, det_bott_th,
        output det_done, det_top_lim, det_bott_lim
    );
endinterface

// File: rtl/lim_scheduler.sv
// lim_scheduler: round-robin time-sharing of one limit detector among NUM_CH channels.
// Optional WAIT watchdog enabled by defining LIM_SCHED_WATCHDOG_EN.
module lim_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*DATA_W-1:0] ch_level,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_ch,
    input  logic [DATA_W-1:0]        cfg_top,
    input  logic [DATA_W-1:0]        cfg_bott,
    lim_scheduler_if.master          det,
    output logic [NUM_CH-1:0]        grant,
    output logic [NUM_CH-1:0]        top_lim,
    output logic [NUM_CH-1:0]        bott_lim,
    output logic                     busy,
    output logic                     err
);

    localparam int unsigned NCH   = NUM_CH;
    localparam int          IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT < 1) begin : g_cfg_check
        $error("lim_scheduler: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, STORE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  gidx;
    logic [IDX_W-1:0]  next_ptr;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_vld;
    int unsigned       cand;
    logic [DATA_W-1:0] top_th  [NUM_CH];
    logic [DATA_W-1:0] bott_th [NUM_CH];

    // First requester at or after rr_ptr, searching modulo NUM_CH.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = (32'(rr_ptr) + k) % NCH;
            if (!pick_vld && ch_req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(cand);
            end
        end
    end

    assign next_ptr = (gidx == IDX_W'(NCH - 1)) ? '0 : gidx + 1'b1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                top_th[i]  <= '1;
                bott_th[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (cfg_ch == 3'(i)) begin
                    top_th[i]  <= cfg_top;
                    bott_th[i] <= cfg_bott;
                end
            end
        end
    end

`ifdef LIM_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            gidx            <= '0;
            grant           <= '0;
            top_lim         <= '0;
            bott_lim        <= '0;
            det.det_start   <= 1'b0;
            det.det_level   <= '0;
            det.det_top_th  <= '0;
            det.det_bott_th <= '0;
`ifdef LIM_SCHED_WATCHDOG_EN
            wd_cnt          <= '0;
            err_q           <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|ch_req) state <= ARB;
                end
                ARB: begin
                    if (pick_vld) begin
                        gidx            <= pick_idx;
                        grant           <= NUM_CH'(1) << pick_idx;
                        det.det_level   <= ch_level[32'(pick_idx)*DATA_W +: DATA_W];
                        det.det_top_th  <= top_th[pick_idx];
                        det.det_bott_th <= bott_th[pick_idx];
                        det.det_start   <= 1'b1;
                        state           <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    det.det_start <= 1'b0;
`ifdef LIM_SCHED_WATCHDOG_EN
                    wd_cnt        <= '0;
`endif
                    state         <= WAIT;
                end
                WAIT: begin
                    // Flags are taken on the done edge so the detector result is
                    // sampled while valid; they are visible throughout STORE.
                    if (det.det_done) begin
                        top_lim[gidx]  <= det.det_top_lim;
                        bott_lim[gidx] <= det.det_bott_lim;
                        state          <= STORE;
`ifdef LIM_SCHED_WATCHDOG_EN
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= STORE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                STORE: begin
                    rr_ptr <= next_ptr;
                    grant  <= '0;
                    state  <= (|ch_req) ? ARB : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lim_scheduler.sv
// tb_lim_scheduler: table vectors, directed corner sequences and a randomized run
// against a round-robin reference model for lim_scheduler (NUM_CH=4, DATA_W=8).
module tb_lim_scheduler;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic [3:0]  ch_req = '0;
    logic [31:0] ch_level = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic [7:0]  cfg_top = '0;
    logic [7:0]  cfg_bott = '0;
    logic [3:0]  grant, top_lim, bott_lim;
    logic        busy, err;

    int checks = 0;
    int failures = 0;

    lim_scheduler_if #(.DATA_W(8)) dif ();

    lim_scheduler #(.NUM_CH(4), .DATA_W(8), .TIMEOUT(16)) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .ch_req   (ch_req),
        .ch_level (ch_level),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_top  (cfg_top),
        .cfg_bott (cfg_bott),
        .det      (dif.master),
        .grant    (grant),
        .top_lim  (top_lim),
        .bott_lim (bott_lim),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [7:0] lvl;
        logic       rt, rb;
        logic [3:0] exp_g;
        logic [7:0] exp_lvl, exp_tth, exp_bth;
        logic [3:0] exp_tl, exp_bl;
    } vec_t;

    vec_t tbl[7];

    // Reference model state
    logic [7:0] m_top[4];
    logic [7:0] m_bott[4];
    logic [3:0] m_tl, m_bl;
    int         m_rr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] req, input int rr);
        for (int k = 0; k < 4; k++)
            if (req[(rr + k) % 4]) return (rr + k) % 4;
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [7:0] t, input logic [7:0] b);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = ch; cfg_top = t; cfg_bott = b;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dif.det_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL det_start_timeout: no start pulse within 20 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("return_to_idle", {31'd0, ok}, 32'd1);
    endtask

    // One detector transaction: returns at the negedge after det_done (STORE).
    task automatic serve(input logic [3:0] req_next, input logic [31:0] lvl_next,
                         input logic rt, input logic rb, input int dly,
                         input bit do_cfg, input logic [2:0] wch,
                         input logic [7:0] wt, input logic [7:0] wb,
                         output logic [3:0] g, output logic [7:0] lv,
                         output logic [7:0] tth, output logic [7:0] bth, output bit ok);
        wait_start(ok);
        g = grant; lv = dif.det_level; tth = dif.det_top_th; bth = dif.det_bott_th;
        if (!ok) return;
        ch_req = req_next;
        ch_level = lvl_next;
        @(negedge clk);
        chk("start_one_cycle", {31'd0, dif.det_start}, 32'd0);
        if (do_cfg) begin
            cfg_we = 1'b1; cfg_ch = wch; cfg_top = wt; cfg_bott = wb;
        end
        @(negedge clk);
        cfg_we = 1'b0;
        chk("hold_grant", {28'd0, grant}, {28'd0, g});
        chk("hold_top_th", {24'd0, dif.det_top_th}, {24'd0, tth});
        chk("hold_bott_th", {24'd0, dif.det_bott_th}, {24'd0, bth});
        chk("hold_level", {24'd0, dif.det_level}, {24'd0, lv});
        repeat (dly) @(negedge clk);
        dif.det_done = 1'b1; dif.det_top_lim = rt; dif.det_bott_lim = rb;
        @(negedge clk);
        dif.det_done = 1'b0; dif.det_top_lim = 1'b0; dif.det_bott_lim = 1'b0;
    endtask

    initial begin
        logic [3:0] g;
        logic [7:0] lv, tth, bth;
        bit ok;
        logic [3:0] cur_req, nreq;
        logic [31:0] cur_lvl, nlvl;
        logic rt, rb, do_cfg;
        logic [2:0] wch;
        logic [7:0] wt, wb;
        int ch;

        dif.det_done = 1'b0; dif.det_top_lim = 1'b0; dif.det_bott_lim = 1'b0;

        tbl[0] = '{4'b0001, 8'd10, 1'b0, 1'b1, 4'b0001, 8'd10, 8'd200, 8'd50,  4'b0000, 4'b0001};
        tbl[1] = '{4'b0001, 8'd20, 1'b1, 1'b0, 4'b0001, 8'd20, 8'd200, 8'd50,  4'b0001, 4'b0000};
        tbl[2] = '{4'b1010, 8'd30, 1'b1, 1'b1, 4'b0010, 8'd31, 8'd100, 8'd20,  4'b0011, 4'b0010};
        tbl[3] = '{4'b1010, 8'd40, 1'b0, 1'b1, 4'b1000, 8'd43, 8'd250, 8'd5,   4'b0011, 4'b1010};
        tbl[4] = '{4'b0110, 8'd50, 1'b0, 1'b0, 4'b0010, 8'd51, 8'd100, 8'd20,  4'b0001, 4'b1000};
        tbl[5] = '{4'b1111, 8'd60, 1'b1, 1'b0, 4'b0100, 8'd62, 8'd150, 8'd30,  4'b0101, 4'b1000};
        tbl[6] = '{4'b0101, 8'd70, 1'b0, 1'b0, 4'b0001, 8'd70, 8'd200, 8'd50,  4'b0100, 4'b1000};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_top_lim", {28'd0, top_lim}, 32'd0);
        chk("rst_bott_lim", {28'd0, bott_lim}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_det_start", {31'd0, dif.det_start}, 32'd0);
        chk("rst_det_level", {24'd0, dif.det_level}, 32'd0);
        chk("rst_det_th", {16'd0, dif.det_top_th, dif.det_bott_th}, 32'd0);
        reset_L = 1'b1;
        @(negedge clk);

        // Single request, cycle-accurate latency
        cfg_write(3'd2, 8'd200, 8'd50);
        ch_level = {8'd0, 8'd210, 8'd0, 8'd0};
        ch_req = 4'b0100;
        @(negedge clk);
        chk("single_arb_busy", {31'd0, busy}, 32'd1);
        chk("single_arb_nostart", {31'd0, dif.det_start}, 32'd0);
        @(negedge clk);
        chk("single_start", {31'd0, dif.det_start}, 32'd1);
        chk("single_grant", {28'd0, grant}, 32'b0100);
        chk("single_level", {24'd0, dif.det_level}, 32'd210);
        chk("single_top_th", {24'd0, dif.det_top_th}, 32'd200);
        chk("single_bott_th", {24'd0, dif.det_bott_th}, 32'd50);
        @(negedge clk);
        chk("single_start_low", {31'd0, dif.det_start}, 32'd0);
        ch_req = 4'b0000;
        dif.det_done = 1'b1; dif.det_top_lim = 1'b1;
        @(negedge clk);
        dif.det_done = 1'b0; dif.det_top_lim = 1'b0;
        chk("single_top_lim", {28'd0, top_lim}, 32'b0100);
        chk("single_bott_lim", {28'd0, bott_lim}, 32'd0);
        wait_idle();

        // Reset asserted mid-WAIT, then a stray det_done
        ch_req = 4'b0010;
        wait_start(ok);
        @(negedge clk);
        reset_L = 1'b0;
        #1;
        chk("midrst_grant", {28'd0, grant}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_flags", {24'd0, top_lim, bott_lim}, 32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        ch_req = 4'b0000;
        dif.det_done = 1'b1; dif.det_top_lim = 1'b1; dif.det_bott_lim = 1'b1;
        @(negedge clk);
        dif.det_done = 1'b0; dif.det_top_lim = 1'b0; dif.det_bott_lim = 1'b0;
        @(negedge clk);
        chk("stray_done_flags", {24'd0, top_lim, bott_lim}, 32'd0);
        chk("stray_done_busy", {31'd0, busy}, 32'd0);

        // Table-driven transactions from a fresh reset
        do_reset();
        cfg_write(3'd0, 8'd200, 8'd50);
        cfg_write(3'd1, 8'd100, 8'd20);
        cfg_write(3'd2, 8'd150, 8'd30);
        cfg_write(3'd3, 8'd250, 8'd5);
        cfg_write(3'd7, 8'd1, 8'd1);
        for (int i = 0; i < 7; i++) begin
            ch_level = {tbl[i].lvl + 8'd3, tbl[i].lvl + 8'd2, tbl[i].lvl + 8'd1, tbl[i].lvl};
            ch_req = tbl[i].req;
            serve(4'b0000, ch_level, tbl[i].rt, tbl[i].rb, 1, 1'b0, 3'd0, 8'd0, 8'd0,
                  g, lv, tth, bth, ok);
            chk($sformatf("tbl%0d_grant", i), {28'd0, g}, {28'd0, tbl[i].exp_g});
            chk($sformatf("tbl%0d_level", i), {24'd0, lv}, {24'd0, tbl[i].exp_lvl});
            chk($sformatf("tbl%0d_th", i), {16'd0, tth, bth}, {16'd0, tbl[i].exp_tth, tbl[i].exp_bth});
            chk($sformatf("tbl%0d_flags", i), {24'd0, top_lim, bott_lim},
                {24'd0, tbl[i].exp_tl, tbl[i].exp_bl});
            wait_idle();
        end

        // Config write to the granted channel during WAIT, then wrap-around
        ch_req = 4'b0010;
        serve(4'b0010, ch_level, 1'b0, 1'b0, 0, 1'b1, 3'd1, 8'd120, 8'd20, g, lv, tth, bth, ok);
        chk("cfgwait_first_th", {24'd0, tth}, 32'd100);
        serve(4'b0100, ch_level, 1'b0, 1'b0, 0, 1'b1, 3'd7, 8'd1, 8'd1, g, lv, tth, bth, ok);
        chk("cfgwait_regrant", {28'd0, g}, 32'b0010);
        chk("cfgwait_new_th", {24'd0, tth}, 32'd120);
        serve(4'b1001, ch_level, 1'b0, 1'b0, 0, 1'b0, 3'd0, 8'd0, 8'd0, g, lv, tth, bth, ok);
        chk("wrap_pre_grant", {28'd0, g}, 32'b0100);
        serve(4'b1001, ch_level, 1'b0, 1'b0, 2, 1'b0, 3'd0, 8'd0, 8'd0, g, lv, tth, bth, ok);
        chk("wrap_ch3_grant", {28'd0, g}, 32'b1000);
        serve(4'b0000, ch_level, 1'b0, 1'b0, 0, 1'b0, 3'd0, 8'd0, 8'd0, g, lv, tth, bth, ok);
        chk("wrap_ch0_grant", {28'd0, g}, 32'b0001);
        wait_idle();

        // Randomized back-to-back traffic against the reference model
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m_top[i] = 8'hFF;
            m_bott[i] = 8'h00;
        end
        m_tl = '0; m_bl = '0; m_rr = 0;
        cur_req = 4'($urandom_range(1, 15));
        cur_lvl = $urandom;
        ch_req = cur_req;
        ch_level = cur_lvl;
        for (int it = 0; it < 120; it++) begin
            nreq = 4'($urandom_range(1, 15));
            nlvl = $urandom;
            rt = 1'($urandom); rb = 1'($urandom);
            do_cfg = 1'($urandom_range(0, 2) == 0);
            wch = 3'($urandom);
            wt = 8'($urandom); wb = 8'($urandom);
            serve(nreq, nlvl, rt, rb, $urandom_range(0, 3), do_cfg, wch, wt, wb,
                  g, lv, tth, bth, ok);
            if (!ok) break;
            ch = pick(cur_req, m_rr);
            chk("rnd_grant", {28'd0, g}, 32'(1) << ch);
            chk("rnd_level", {24'd0, lv}, {24'd0, cur_lvl[ch*8 +: 8]});
            chk("rnd_th", {16'd0, tth, bth}, {16'd0, m_top[ch], m_bott[ch]});
            if (do_cfg && wch < 3'd4) begin
                m_top[wch] = wt;
                m_bott[wch] = wb;
            end
            m_tl[ch] = rt;
            m_bl[ch] = rb;
            m_rr = (ch + 1) % 4;
            chk("rnd_flags", {24'd0, top_lim, bott_lim}, {24'd0, m_tl, m_bl});
            cur_req = nreq;
            cur_lvl = nlvl;
        end

        // Detector never answers
        ch = pick(cur_req, m_rr);
        wait_start(ok);
        chk("nodone_grant", {28'd0, grant}, 32'(1) << ch);
`ifdef LIM_SCHED_WATCHDOG_EN
        begin
            int n = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (err) begin
                    n = i;
                    break;
                end
            end
            chk("wd_abort_cycle", n, 17);
            chk("wd_flags_kept", {24'd0, top_lim, bott_lim}, {24'd0, m_tl, m_bl});
            wait_start(ok);
            chk("wd_next_grant", {28'd0, grant}, 32'(1) << pick(cur_req, (ch + 1) % 4));
            chk("wd_err_sticky", {31'd0, err}, 32'd1);
        end
`else
        repeat (40) @(negedge clk);
        chk("nodone_busy", {31'd0, busy}, 32'd1);
        chk("nodone_err", {31'd0, err}, 32'd0);
        chk("nodone_grant_held", {28'd0, grant}, 32'(1) << ch);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
